// File: rtl/imem_pkg.sv
// Shared constants, address-split helper and defaults for the instruction fetch buffer.
package imem_pkg;

    localparam int unsigned DEF_DEPTH   = 16;
    localparam int unsigned DEF_FIELDS  = 8;
    localparam int unsigned DEF_FIELD_W = 32;
    localparam int unsigned DEF_EXT_W   = 32;

    localparam int unsigned FIELD_IDX_W = $clog2(DEF_FIELDS);
    localparam int unsigned INSTR_IDX_W = $clog2(DEF_DEPTH);

    // Wide enough for any supported external address width
    localparam int unsigned ADDR_W = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] index;
        logic [ADDR_W-1:0] field;
    } addr_split_t;

    // Flat field address -> (instruction index, field within instruction)
    function automatic addr_split_t split_addr(input logic [ADDR_W-1:0] addr,
                                               input int unsigned       field_idx_w);
        addr_split_t s;
        s.index = addr >> field_idx_w;
        s.field = addr & ((ADDR_W'(1) << field_idx_w) - ADDR_W'(1));
        return s;
    endfunction

endpackage

// File: rtl/imem_rsp_reg.sv
// One-entry valid/ready output register; accepts a new entry whenever empty or draining.
module imem_rsp_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready_c,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready_c = !r_valid || i_ready;
    assign o_valid   = r_valid;
    assign o_data    = r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready_c) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/imem_fetch_buffer.sv
// Field-wise loadable instruction store with per-field load tracking and a registered fetch port.
module imem_fetch_buffer
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned FIELDS  = DEF_FIELDS,
    parameter int unsigned FIELD_W = DEF_FIELD_W,
    parameter int unsigned EXT_W   = DEF_EXT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [EXT_W-1:0]             wr_addr,
    input  logic [EXT_W-1:0]             wr_data,
    output logic                         wr_err,
    output logic [$clog2(DEPTH+1)-1:0]   loaded_count,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_pc,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [FIELDS*FIELD_W-1:0]    rsp_instr,
    output logic                         rsp_incomplete,
    output logic                         rsp_err
);

    localparam int unsigned F_IDX_W = $clog2(FIELDS);
    localparam int unsigned I_IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH+1);
    localparam int unsigned INSTR_W = FIELDS*FIELD_W;
    localparam int unsigned RSP_W   = INSTR_W + 2;

    logic [FIELD_W-1:0] r_mem    [DEPTH][FIELDS];
    logic [FIELDS-1:0]  r_bitmap [DEPTH];
    logic               r_wr_err;
    logic [CNT_W-1:0]   r_count;

    addr_split_t        w_split;
    logic               w_wr_in_range;
    logic [I_IDX_W-1:0] w_wr_idx;
    logic [F_IDX_W-1:0] w_wr_field;
    logic [FIELDS-1:0]  w_field_bit;
    logic [FIELDS-1:0]  w_wr_row;
    logic               w_completes;

    // Write decode; an instruction completes when its last missing field lands
    always_comb begin
        w_split       = split_addr(ADDR_W'(wr_addr), F_IDX_W);
        w_wr_in_range = w_split.index < ADDR_W'(DEPTH);
        w_wr_idx      = I_IDX_W'(w_split.index);
        w_wr_field    = F_IDX_W'(w_split.field);
        w_field_bit   = FIELDS'(1) << w_wr_field;
        w_wr_row      = w_wr_in_range ? r_bitmap[w_wr_idx] : '0;
        w_completes   = ((w_wr_row & w_field_bit) == '0) && ((w_wr_row | w_field_bit) == '1);
    end

    // Storage, load bitmap, counter and sticky error; clear drops any same-cycle write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_bitmap[i] <= '0;
                for (int unsigned f = 0; f < FIELDS; f++) begin
                    r_mem[i][f] <= '0;
                end
            end
            r_wr_err <= 1'b0;
            r_count  <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_bitmap[i] <= '0;
            end
            r_wr_err <= 1'b0;
            r_count  <= '0;
        end else if (wr_en) begin
            if (w_wr_in_range) begin
                r_mem[w_wr_idx][w_wr_field] <= wr_data[FIELD_W-1:0];
                r_bitmap[w_wr_idx]          <= w_wr_row | w_field_bit;
                if (w_completes && (r_count < CNT_W'(DEPTH))) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else begin
                r_wr_err <= 1'b1;
            end
        end
    end

    logic               w_pc_ok;
    logic [I_IDX_W-1:0] w_pc_idx;
    logic [INSTR_W-1:0] w_fetch_instr;
    logic               w_fetch_incomplete;
    logic [RSP_W-1:0]   w_rsp_d;
    logic [RSP_W-1:0]   w_rsp_q;

    // Fetch reads current register state, so a same-cycle write is not yet visible
    always_comb begin
        w_pc_ok       = req_pc < 32'(DEPTH);
        w_pc_idx      = I_IDX_W'(req_pc);
        w_fetch_instr = '0;
        if (w_pc_ok) begin
            for (int unsigned f = 0; f < FIELDS; f++) begin
                w_fetch_instr[f*FIELD_W +: FIELD_W] = r_mem[w_pc_idx][f];
            end
        end
        w_fetch_incomplete = !w_pc_ok || (r_bitmap[w_pc_idx] != '1);
        w_rsp_d            = {w_fetch_instr, w_fetch_incomplete, !w_pc_ok};
    end

    imem_rsp_reg #(
        .W (RSP_W)
    ) u_rsp_reg (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (req_valid),
        .o_ready_c (req_ready),
        .i_data    (w_rsp_d),
        .o_valid   (rsp_valid),
        .i_ready   (rsp_ready),
        .o_data    (w_rsp_q)
    );

    assign {rsp_instr, rsp_incomplete, rsp_err} = w_rsp_q;
    assign wr_err       = r_wr_err;
    assign loaded_count = r_count;

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Scoreboard bench for imem_fetch_buffer: driver pushes expected responses, monitor pops on handshake.
module tb_imem_fetch_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         wr_en;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         wr_err;
    logic [4:0]   loaded_count;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_pc;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [255:0] rsp_instr;
    logic         rsp_incomplete;
    logic         rsp_err;

    imem_fetch_buffer #(
        .DEPTH   (16),
        .FIELDS  (8),
        .FIELD_W (32),
        .EXT_W   (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .loaded_count   (loaded_count),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pc         (req_pc),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_instr      (rsp_instr),
        .rsp_incomplete (rsp_incomplete),
        .rsp_err        (rsp_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [257:0] sb[$];

    // Reference model of the store
    logic [31:0] m_mem [16][8];
    logic [7:0]  m_bmp [16];
    int          m_cnt;
    logic        m_err;
    logic        m_valid;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_bmp[i] = 8'h00;
            for (int f = 0; f < 8; f++) m_mem[i][f] = 32'h0;
        end
        m_cnt   = 0;
        m_err   = 1'b0;
        m_valid = 1'b0;
    endtask

    function automatic logic [257:0] exp_rsp(input logic [31:0] pc);
        logic [255:0] ins;
        ins = '0;
        if (pc >= 32'd16) return {256'h0, 1'b1, 1'b1};
        for (int f = 0; f < 8; f++) ins[f*32 +: 32] = m_mem[pc[3:0]][f];
        return {ins, (m_bmp[pc[3:0]] != 8'hFF), 1'b0};
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; inputs driven at posedge+1, model updated with read-before-write order
    task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [31:0] pc, input logic clr);
        logic rdy;
        int   idx;
        int   fld;
        wr_en = we; wr_addr = wa; wr_data = wd;
        req_valid = rv; req_pc = pc; clear = clr;
        #1;
        rdy = !m_valid || rsp_ready;
        check("req_ready", 256'(req_ready), 256'(rdy));
        if (rv && rdy) sb.push_back(exp_rsp(pc));
        if (rdy) m_valid = rv;
        if (clr) begin
            for (int i = 0; i < 16; i++) m_bmp[i] = 8'h00;
            m_cnt = 0;
            m_err = 1'b0;
        end else if (we) begin
            idx = int'(wa >> 3);
            fld = int'(wa & 32'd7);
            if (idx < 16) begin
                m_mem[idx][fld] = wd;
                if (!m_bmp[idx][fld]) begin
                    m_bmp[idx][fld] = 1'b1;
                    if (m_bmp[idx] == 8'hFF) m_cnt++;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; req_valid = 1'b0; clear = 1'b0;
        check("wr_err", 256'(wr_err), 256'(m_err));
        check("loaded_count", 256'(loaded_count), 256'(m_cnt));
        check("rsp_valid", 256'(rsp_valid), 256'(m_valid));
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        step(1'b0, 32'h0, 32'h0, 1'b1, pc, 1'b0);
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: compare every handshaken response with the oldest expectation
    initial begin
        logic [257:0] e;
        forever begin
            @(negedge clk);
            if (reset && rsp_valid && rsp_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected actual=%0h required=none",
                             {rsp_instr, rsp_incomplete, rsp_err});
                end else begin
                    e = sb.pop_front();
                    if ({rsp_instr, rsp_incomplete, rsp_err} !== e) begin
                        n_fail++;
                        $display("FAIL rsp actual=%0h required=%0h",
                                 {rsp_instr, rsp_incomplete, rsp_err}, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    logic [257:0] hold_exp;

    initial begin
        reset = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
        model_reset();
        #12;
        check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        check("rst_rsp_instr", rsp_instr, 256'h0);
        check("rst_rsp_flags", 256'({rsp_incomplete, rsp_err}), 256'(0));
        check("rst_req_ready", 256'(req_ready), 256'(1));
        check("rst_wr_err", 256'(wr_err), 256'(0));
        check("rst_count", 256'(loaded_count), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();

        // Empty store fetch
        fetch(32'd0);
        idle();

        // Full load, then fetch PC 5 and PC 15 back-to-back
        for (int a = 0; a < 128; a++) write(32'(a), 32'(a));
        check("full_count", 256'(loaded_count), 256'(16));
        fetch(32'd5);
        fetch(32'd15);
        idle();

        // Partial load of instruction 3
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int f = 0; f < 7; f++) write(32'(24 + f), 32'(32'h300 + f));
        fetch(32'd3);
        check("partial_count", 256'(loaded_count), 256'(0));
        write(32'd31, 32'h307);
        check("complete_count", 256'(loaded_count), 256'(1));
        fetch(32'd3);
        idle();

        // Out-of-range write and fetch
        write(32'd128, 32'hDEAD);
        check("oor_wr_err", 256'(wr_err), 256'(1));
        idle();
        check("oor_wr_err_sticky", 256'(wr_err), 256'(1));
        fetch(32'd16);
        fetch(32'd0);
        idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("clear_wr_err", 256'(wr_err), 256'(0));

        // Backpressure: PC 1 held while PC 2 waits
        rsp_ready = 1'b0;
        hold_exp  = exp_rsp(32'd1);
        fetch(32'd1);
        for (int k = 0; k < 3; k++) begin
            fetch(32'd2);
            check("bp_req_ready", 256'(req_ready), 256'(0));
            check("bp_stable", 256'({rsp_instr, rsp_incomplete, rsp_err}), 256'(hold_exp));
        end
        rsp_ready = 1'b1;
        fetch(32'd2);
        fetch(32'd3);
        idle();
        idle();

        // Same-cycle write and fetch on instruction 2
        for (int f = 1; f < 8; f++) write(32'(16 + f), 32'(32'h200 + f));
        step(1'b1, 32'd16, 32'hA5, 1'b1, 32'd2, 1'b0);
        fetch(32'd2);
        check("hazard_count", 256'(loaded_count), 256'(1));
        idle();

        // Clear with same-cycle write and fetch
        step(1'b1, 32'd32, 32'h77, 1'b1, 32'd2, 1'b1);
        check("clear_count", 256'(loaded_count), 256'(0));
        fetch(32'd4);
        fetch(32'd2);
        idle();

        // Async reset while a response is held
        for (int f = 0; f < 8; f++) write(32'(48 + f), 32'(32'h600 + f));
        rsp_ready = 1'b0;
        fetch(32'd6);
        #2;
        reset = 1'b0;
        #1;
        check("arst_rsp_valid", 256'(rsp_valid), 256'(0));
        check("arst_count", 256'(loaded_count), 256'(0));
        sb.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        fetch(32'd6);
        idle();

        for (int k = 0; k < 20 && sb.size() != 0; k++) idle();
        check("sb_drained", 256'(sb.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_buffer.md
# imem_fetch_buffer

Parametrised instruction store for the MAC engine: the host loads instructions field-by-field over the external 32-bit port, and the controller fetches whole instructions by PC through a valid/ready handshake with a one-cycle registered response. It generalises the fixed 2×8×32 store with configurable depth, field count and field width. It adds the following:
- per-field load tracking;
- a loaded-instruction counter;
- out-of-range write detection;
- a soft clear;
- flagging of incomplete or out-of-range fetches.

## Interface
Parameters:
- DEPTH, 16: number of instructions (≥2).
- FIELDS, 8: fields per instruction, power of two.
- FIELD_W, 32: bits per field, ≤ EXT_W.
- EXT_W, 32: external port width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft clear of load state.
- wr_en  in  1  external write strobe.
- wr_addr  in  EXT_W  flat field address = instr*FIELDS + field.
- wr_data  in  EXT_W  field data; low FIELD_W bits stored.
- wr_err  out  1  sticky: an out-of-range write occurred.
- loaded_count  out  $clog2(DEPTH+1)  number of fully loaded instructions.
- req_valid  in  1  fetch request.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_pc  in  32  instruction index.
- rsp_valid  out  1  response held in output register.
- rsp_ready  in  1  consumer accepts response.
- rsp_instr  out  FIELDS*FIELD_W  fetched instruction; field f at [f*FIELD_W +: FIELD_W].
- rsp_incomplete  out  1  fetched instruction not fully loaded.
- rsp_err  out  1  req_pc ≥ DEPTH.

## Operation
- Write address split:
  - field = wr_addr[log2(FIELDS)-1:0];
  - index = wr_addr >> log2(FIELDS).
- Write with index < DEPTH stores the field and sets its bit in the DEPTH×FIELDS loaded bitmap. Rewriting a field that is already loaded updates its data; the bitmap and count are unchanged.
- Write with index ≥ DEPTH is dropped, and wr_err is set and held.
- loaded_count rules:
  - increments in the cycle an instruction's last missing field is written;
  - never exceeds DEPTH;
  - never decrements except on clear or reset.
- clear:
  - zeroes the bitmap, loaded_count and wr_err;
  - leaves stored data intact;
  - has priority over a same-cycle wr_en, and that write is dropped.
- Fetch is a one-entry output register, and req_ready = !rsp_valid | rsp_ready.
- On an accepted request, the register captures:
  - rsp_instr = memory[req_pc];
  - rsp_incomplete = bitmap row not all-ones;
  - rsp_err = (req_pc ≥ DEPTH).
- When rsp_err = 1, rsp_instr = 0 and rsp_incomplete = 1.
- rsp_valid stays high and all rsp_* outputs stay stable until rsp_ready. Back-to-back accepted requests give one response per cycle.
- A same-cycle write and fetch to the same instruction returns pre-write data and pre-write incomplete status (read-before-write).
- A fetch does not depend on clear. A fetch accepted in a clear cycle reports the pre-clear bitmap.
- Reset values:
  - all stored data and the bitmap are 0;
  - wr_err = 0, loaded_count = 0;
  - rsp_valid = 0, rsp_instr = 0, rsp_incomplete = 0, rsp_err = 0;
  - req_ready = 1.
- Reset asserted mid-transaction discards any pending response.

## Timing
- Fetch latency is 1 cycle: a request accepted at edge N gives rsp_valid high after edge N.
- Throughput is 1 fetch per cycle while rsp_ready = 1.
- A write at edge N is visible to a fetch accepted at edge N+1 or later.
- wr_err and loaded_count update at the edge after the write or clear.
- req_ready is combinational from rsp_valid and rsp_ready only. It does not depend on req_valid.

## Structure
- Package imem_pkg holds:
  - default parameter constants;
  - FIELD_IDX_W = $clog2(FIELDS) and INSTR_IDX_W = $clog2(DEPTH);
  - a function to split wr_addr into (index, field).
- Sub-module imem_rsp_reg: the one-entry valid/ready output register carrying {rsp_instr, rsp_incomplete, rsp_err}.
- Storage, bitmap and counter stay in the top module.

## Test plan
- **Full load, full fetch:** reset; write all 16×8 fields with data = address; fetch PC 5 → loaded_count = 16, rsp_instr field f = 40+f, rsp_incomplete = 0.
- **Partial load:** write fields 0–6 of instr 3 only; fetch PC 3 → rsp_incomplete = 1, loaded_count = 0. Write field 7 → loaded_count = 1; re-fetch gives rsp_incomplete = 0.
- **Out-of-range write and fetch:**
  - write wr_addr = 128 → no change to stored data, wr_err = 1 and stays 1;
  - fetch PC 16 → rsp_err = 1, rsp_instr = 0;
  - clear → wr_err = 0.
- **Backpressure:** issue fetches for PCs 1, 2, 3 with rsp_ready low for 3 cycles → req_ready = 0 and PC 1's response stays stable. Then raise rsp_ready → responses arrive in order 1, 2, 3, one per cycle.
- **Same-cycle hazard:** write 0xA5 to instr 2 field 0 while fetching PC 2 → response shows the old value and old incomplete status; the next fetch shows 0xA5.
- **Clear and reset:**
  - clear with a same-cycle write → write dropped, bitmap empty;
  - async reset asserted while rsp_valid = 1 → rsp_valid = 0 and loaded_count = 0 immediately.
